alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Issue stage that sits directly upstream of the combinational alu. It accepts one instruction per handshake, together with its two register-file read values. It decodes the opcode/funct into the ALU operation code and selects op1/op2 (register, shamt or extended immediate). The decoded operation is buffered in a 2-entry FIFO, and the head entry drives alu.op1/op2/oprn together with the destination register address for writeback.

Parameters:
DATA_WIDTH, 32, operand width (matches `DATA_WIDTH).
OPRN_WIDTH, 6, ALU operation code width (matches `ALU_OPRN_WIDTH).
DEPTH, 2, issue buffer entries (fixed at 2; the parameter exists for assertion checks only).

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST  input  1  reset; synchronous, active-high.
in_valid  input  1  instruction/operands present.
in_ready  output  1  stage can accept (buffer not full).
instr  input  32  instruction word: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0].
rs_data  input  DATA_WIDTH  register-file value of rs.
rt_data  input  DATA_WIDTH  register-file value of rt.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer (ALU/writeback) takes head this cycle.
op1  output  DATA_WIDTH  to alu.op1.
op2  output  DATA_WIDTH  to alu.op2.
oprn  output  OPRN_WIDTH  to alu.oprn.
dest  output  5  writeback register address.
illegal  output  1  head entry was an unsupported instruction.

Behaviour:
- Reset (RST=1 at an edge): buffer emptied. Outputs become out_valid=0, in_ready=1, op1=0, op2=0, oprn=0, dest=0, illegal=0. Reset overrides any handshake in the same cycle.
- Push: in_valid & in_ready at an edge. Pop: out_valid & out_ready at an edge.
- in_ready = (count<2), registered-state only; no combinational path from out_ready. out_valid = (count>0).
- Latency: an instruction pushed into an empty buffer appears on the outputs the cycle after the push edge.
- Simultaneous push and pop (count 1 or 2): count is unchanged and order is preserved; with count 2, in_ready=0 so no push occurs.
- Head outputs hold stable while out_valid=1 and out_ready=0. Outputs are don't-care (hold last value) while out_valid=0.
- R-type decode (opcode 0x00), op1=rs_data, op2=rt_data, dest=rd:
  funct 0x20 add->0x01, 0x22 sub->0x02, 0x2c mul->0x03, 0x24 and->0x06, 0x25 or->0x07, 0x27 nor->0x08, 0x2a slt->0x09.
- R-type shifts: funct 0x02 srl->0x04 and 0x01 sll->0x05, with op1=rs_data, op2=zero-extended shamt.
- I-type decode, op1=rs_data, dest=rt:
  0x08 addi->0x01 and 0x1d muli->0x03, op2=sign-ext imm.
  0x0c andi->0x06 and 0x0d ori->0x07, op2=zero-ext imm.
  0x0a slti->0x09, op2=sign-ext imm.
  0x0f lui->0x05, op1=zero-ext imm, op2=16.
- Any other opcode/funct: entry still buffered with illegal=1, oprn=0x00, op1=op2=0, dest=0. The consumer must drop it.
- Inputs are sampled only at the push edge; later changes to rs_data/rt_data do not affect buffered entries.

Decomposition:
- prj_definition.v: add opcode and funct constants, the ISSUE_DEPTH constant, and the reuse of `ALU_OPRN_WIDTH'hNN operation codes.
- Sub-module alu_issue_decode: purely combinational instr/rs_data/rt_data -> {op1, op2, oprn, dest, illegal}.
- The top level holds the 2-entry buffer (two entry registers, read/write pointer bits, 2-bit count).

Test Plan:
- Reset then add: RST for 2 cycles -> out_valid=0, in_ready=1, all outputs 0. Push R-type add (funct 0x20, rd=3, rs_data=15, rt_data=3) -> next cycle out_valid=1, op1=15, op2=3, oprn=0x01, dest=3; alu result 18.
- Shift and lui: push sll with shamt=3, rs_data=12 -> op2=3, oprn=0x05, alu result 96. Push lui imm=0x1234 -> op1=0x1234, op2=16, oprn=0x05, alu result 0x12340000.
- Immediate extension: addi imm=0xFFFF, rs_data=5 -> op2=0xFFFFFFFF, result 4. andi imm=0xFFFF -> op2=0x0000FFFF.
- Backpressure: out_ready=0, push 3 instructions back-to-back -> in_ready=0 after the second push, third not accepted. Raise out_ready -> entries emerge in order, then third accepted. No loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles -> one entry per cycle, count never exceeds 1, order preserved.
- Illegal and reset: push opcode 0x3f -> illegal=1, oprn=0. With 2 entries buffered, assert RST with out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing popped.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: opcode/funct encodings, ALU
// operation codes and the issue buffer depth.
package alu_issue_pkg;

   localparam int ISSUE_DEPTH = 2;
   localparam int OPRN_W      = 6;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_SLTI  = 6'h0a;
   localparam logic [5:0] OPC_ANDI  = 6'h0c;
   localparam logic [5:0] OPC_ORI   = 6'h0d;
   localparam logic [5:0] OPC_LUI   = 6'h0f;
   localparam logic [5:0] OPC_MULI  = 6'h1d;

   localparam logic [5:0] FN_SLL = 6'h01;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2a;
   localparam logic [5:0] FN_MUL = 6'h2c;

   localparam logic [OPRN_W-1:0] ALU_NOP = 6'h00;
   localparam logic [OPRN_W-1:0] ALU_ADD = 6'h01;
   localparam logic [OPRN_W-1:0] ALU_SUB = 6'h02;
   localparam logic [OPRN_W-1:0] ALU_MUL = 6'h03;
   localparam logic [OPRN_W-1:0] ALU_SRL = 6'h04;
   localparam logic [OPRN_W-1:0] ALU_SLL = 6'h05;
   localparam logic [OPRN_W-1:0] ALU_AND = 6'h06;
   localparam logic [OPRN_W-1:0] ALU_OR  = 6'h07;
   localparam logic [OPRN_W-1:0] ALU_NOR = 6'h08;
   localparam logic [OPRN_W-1:0] ALU_SLT = 6'h09;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one instruction into ALU operands, operation code
// and writeback address. Unsupported encodings come out as an all-zero NOP.
module alu_issue_decode
   import alu_issue_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OPRN_WIDTH = 6
) (
   input  logic [31:0]           instr,
   input  logic [DATA_WIDTH-1:0] rs_data,
   input  logic [DATA_WIDTH-1:0] rt_data,
   output logic [DATA_WIDTH-1:0] op1,
   output logic [DATA_WIDTH-1:0] op2,
   output logic [OPRN_WIDTH-1:0] oprn,
   output logic [4:0]            dest,
   output logic                  illegal
);

   logic [5:0]            opcode;
   logic [4:0]            rt;
   logic [4:0]            rd;
   logic [4:0]            shamt;
   logic [5:0]            funct;
   logic [15:0]           imm;
   logic [DATA_WIDTH-1:0] imm_sext;
   logic [DATA_WIDTH-1:0] imm_zext;
   logic                  unused_rs;

   assign opcode    = instr[31:26];
   assign rt        = instr[20:16];
   assign rd        = instr[15:11];
   assign shamt     = instr[10:6];
   assign funct     = instr[5:0];
   assign imm       = instr[15:0];
   assign imm_sext  = {{(DATA_WIDTH-16){imm[15]}}, imm};
   assign imm_zext  = {{(DATA_WIDTH-16){1'b0}}, imm};
   // register address of rs is resolved upstream; only its data is used here
   assign unused_rs = ^instr[25:21];

   always_comb begin
      op1     = '0;
      op2     = '0;
      oprn    = '0;
      dest    = '0;
      illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            op1  = rs_data;
            op2  = rt_data;
            dest = rd;
            case (funct)
               FN_ADD:  oprn = OPRN_WIDTH'(ALU_ADD);
               FN_SUB:  oprn = OPRN_WIDTH'(ALU_SUB);
               FN_MUL:  oprn = OPRN_WIDTH'(ALU_MUL);
               FN_AND:  oprn = OPRN_WIDTH'(ALU_AND);
               FN_OR:   oprn = OPRN_WIDTH'(ALU_OR);
               FN_NOR:  oprn = OPRN_WIDTH'(ALU_NOR);
               FN_SLT:  oprn = OPRN_WIDTH'(ALU_SLT);
               FN_SRL: begin
                  oprn = OPRN_WIDTH'(ALU_SRL);
                  op2  = DATA_WIDTH'(shamt);
               end
               FN_SLL: begin
                  oprn = OPRN_WIDTH'(ALU_SLL);
                  op2  = DATA_WIDTH'(shamt);
               end
               default: begin
                  op1     = '0;
                  op2     = '0;
                  dest    = '0;
                  illegal = 1'b1;
               end
            endcase
         end
         OPC_ADDI: begin
            op1 = rs_data; op2 = imm_sext; dest = rt; oprn = OPRN_WIDTH'(ALU_ADD);
         end
         OPC_MULI: begin
            op1 = rs_data; op2 = imm_sext; dest = rt; oprn = OPRN_WIDTH'(ALU_MUL);
         end
         OPC_ANDI: begin
            op1 = rs_data; op2 = imm_zext; dest = rt; oprn = OPRN_WIDTH'(ALU_AND);
         end
         OPC_ORI: begin
            op1 = rs_data; op2 = imm_zext; dest = rt; oprn = OPRN_WIDTH'(ALU_OR);
         end
         OPC_SLTI: begin
            op1 = rs_data; op2 = imm_sext; dest = rt; oprn = OPRN_WIDTH'(ALU_SLT);
         end
         // lui is a left shift of the immediate by a half word
         OPC_LUI: begin
            op1 = imm_zext; op2 = DATA_WIDTH'(16); dest = rt; oprn = OPRN_WIDTH'(ALU_SLL);
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the ALU: decodes each accepted instruction and holds it
// in a 2-entry buffer whose head drives the ALU operands and writeback address.
module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OPRN_WIDTH = 6,
   parameter int DEPTH      = ISSUE_DEPTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   input  logic [DATA_WIDTH-1:0] rs_data,
   input  logic [DATA_WIDTH-1:0] rt_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] op1,
   output logic [DATA_WIDTH-1:0] op2,
   output logic [OPRN_WIDTH-1:0] oprn,
   output logic [4:0]            dest,
   output logic                  illegal
);

   logic [DATA_WIDTH-1:0] dec_op1;
   logic [DATA_WIDTH-1:0] dec_op2;
   logic [OPRN_WIDTH-1:0] dec_oprn;
   logic [4:0]            dec_dest;
   logic                  dec_illegal;

   logic [DATA_WIDTH-1:0] op1_q     [2];
   logic [DATA_WIDTH-1:0] op2_q     [2];
   logic [OPRN_WIDTH-1:0] oprn_q    [2];
   logic [4:0]            dest_q    [2];
   logic                  illegal_q [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic                  push;
   logic                  pop;

   alu_issue_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .OPRN_WIDTH (OPRN_WIDTH)
   ) u_decode (
      .instr   (instr),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .op1     (dec_op1),
      .op2     (dec_op2),
      .oprn    (dec_oprn),
      .dest    (dec_dest),
      .illegal (dec_illegal)
   );

   // ready depends only on stored occupancy, never on out_ready
   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign op1     = op1_q[rd_ptr];
   assign op2     = op2_q[rd_ptr];
   assign oprn    = oprn_q[rd_ptr];
   assign dest    = dest_q[rd_ptr];
   assign illegal = illegal_q[rd_ptr];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < 2; k++) begin
            op1_q[k]     <= '0;
            op2_q[k]     <= '0;
            oprn_q[k]    <= '0;
            dest_q[k]    <= '0;
            illegal_q[k] <= 1'b0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            op1_q[wr_ptr]     <= dec_op1;
            op2_q[wr_ptr]     <= dec_op2;
            oprn_q[wr_ptr]    <= dec_oprn;
            dest_q[wr_ptr]    <= dec_dest;
            illegal_q[wr_ptr] <= dec_illegal;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   count_in_range: assert property (@(posedge CLK) disable iff (RST) count <= 2'(DEPTH));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected decodes are queued at each
// accepted push and compared when the head is consumed.
module tb_alu_issue_stage;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [5:0]  oprn;
      logic [4:0]  dest;
      logic        illegal;
      logic        has_res;
      logic [31:0] res;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [5:0]  oprn;
   logic [4:0]  dest;
   logic        illegal;

   exp_t sb[$];
   exp_t exp_in;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_pop = 0;
   logic streaming = 1'b0;

   always #5 CLK = ~CLK;

   alu_issue_stage dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op1       (op1),
      .op2       (op2),
      .oprn      (oprn),
      .dest      (dest),
      .illegal   (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] sh);
      return {6'h00, 5'd1, 5'd2, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rt, input logic [15:0] imm);
      return {opc, 5'd1, rt, imm};
   endfunction

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [5:0] o,
                               input logic [4:0] d, input logic ill, input logic hr, input logic [31:0] r);
      exp_t e;
      e.op1 = a; e.op2 = b; e.oprn = o; e.dest = d; e.illegal = ill; e.has_res = hr; e.res = r;
      return e;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [5:0] o);
      case (o)
         6'h01:   return a + b;
         6'h02:   return a - b;
         6'h03:   return a * b;
         6'h04:   return a >> b;
         6'h05:   return a << b;
         6'h06:   return a & b;
         6'h07:   return a | b;
         6'h08:   return ~(a | b);
         6'h09:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   always @(negedge CLK) begin
      exp_t e;
      if (!RST) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_pop", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               n_pop++;
               chk("op1", op1, e.op1);
               chk("op2", op2, e.op2);
               chk("oprn", 32'(oprn), 32'(e.oprn));
               chk("dest", 32'(dest), 32'(e.dest));
               chk("illegal", 32'(illegal), 32'(e.illegal));
               if (e.has_res) chk("alu_res", alu_ref(op1, op2, oprn), e.res);
            end
         end
         if (in_valid && in_ready) sb.push_back(exp_in);
         if (streaming) chk("stream_in_ready", 32'(in_ready), 32'd1);
      end
   end

   // caller is at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input exp_t e);
      bit done = 0;
      instr = i; rs_data = a; rt_data = b; exp_in = e; in_valid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge CLK);
         if (in_ready) done = 1;
         @(posedge CLK);
         #1;
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge CLK);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; rs_data = '0; rt_data = '0;
      exp_in = mk(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_op1", op1, 32'd0);
      chk("rst_op2", op2, 32'd0);
      chk("rst_oprn", 32'(oprn), 32'd0);
      chk("rst_dest", 32'(dest), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      @(posedge CLK);
      #1;

      // single instructions, consumer always ready
      out_ready = 1'b1;
      send(rtype(6'h20, 5'd3, 5'd0), 32'd15, 32'd3, mk(15, 3, 6'h01, 3, 0, 1, 32'd18));
      @(negedge CLK);
      chk("latency_valid", 32'(out_valid), 32'd1);
      @(posedge CLK);
      #1;
      send(rtype(6'h01, 5'd4, 5'd3), 32'd12, 32'd77, mk(12, 3, 6'h05, 4, 0, 1, 32'd96));
      send(itype(6'h0f, 5'd7, 16'h1234), 32'hdead_beef, 32'd0,
           mk(32'h1234, 16, 6'h05, 7, 0, 1, 32'h1234_0000));
      send(itype(6'h08, 5'd9, 16'hffff), 32'd5, 32'd0, mk(5, 32'hffff_ffff, 6'h01, 9, 0, 1, 32'd4));
      send(itype(6'h0c, 5'd10, 16'hffff), 32'h1234_5678, 32'd0,
           mk(32'h1234_5678, 32'h0000_ffff, 6'h06, 10, 0, 1, 32'h5678));
      drain();

      // backpressure: third instruction must wait until the head drains
      out_ready = 1'b0;
      send(rtype(6'h22, 5'd11, 5'd0), 32'd50, 32'd8, mk(50, 8, 6'h02, 11, 0, 1, 32'd42));
      send(rtype(6'h24, 5'd12, 5'd0), 32'hf0, 32'h3c, mk(32'hf0, 32'h3c, 6'h06, 12, 0, 1, 32'h30));
      instr = rtype(6'h25, 5'd13, 5'd0); rs_data = 32'h0f; rt_data = 32'h30; in_valid = 1'b1;
      exp_in = mk(32'h0f, 32'h30, 6'h07, 13, 0, 1, 32'h3f);
      for (int t = 0; t < 3; t++) begin
         @(negedge CLK);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_head_hold", op1, 32'd50);
      end
      @(posedge CLK);
      #1 out_ready = 1'b1;
      send(rtype(6'h25, 5'd13, 5'd0), 32'h0f, 32'h30, mk(32'h0f, 32'h30, 6'h07, 13, 0, 1, 32'h3f));
      drain();

      // streaming: one entry per cycle, occupancy never reaches 2
      streaming = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic [31:0] a;
         a = 32'(100 + i);
         case (i)
            0: send(rtype(6'h20, 5'(i), 5'd0), a, 7, mk(a, 7, 6'h01, 5'(i), 0, 0, 0));
            1: send(rtype(6'h22, 5'(i), 5'd0), a, 7, mk(a, 7, 6'h02, 5'(i), 0, 0, 0));
            2: send(rtype(6'h2c, 5'(i), 5'd0), a, 7, mk(a, 7, 6'h03, 5'(i), 0, 0, 0));
            3: send(rtype(6'h27, 5'(i), 5'd0), a, 7, mk(a, 7, 6'h08, 5'(i), 0, 0, 0));
            4: send(rtype(6'h2a, 5'(i), 5'd0), a, 7, mk(a, 7, 6'h09, 5'(i), 0, 0, 0));
            5: send(rtype(6'h02, 5'(i), 5'd2), a, 7, mk(a, 2, 6'h04, 5'(i), 0, 0, 0));
            6: send(itype(6'h0d, 5'(i), 16'h00f0), a, 7, mk(a, 32'hf0, 6'h07, 5'(i), 0, 0, 0));
            7: send(itype(6'h0a, 5'(i), 16'hfffe), a, 7, mk(a, 32'hffff_fffe, 6'h09, 5'(i), 0, 0, 0));
            8: send(itype(6'h1d, 5'(i), 16'h0003), a, 7, mk(a, 3, 6'h03, 5'(i), 0, 0, 0));
            default: send(rtype(6'h24, 5'(i), 5'd0), a, 7, mk(a, 7, 6'h06, 5'(i), 0, 0, 0));
         endcase
      end
      streaming = 1'b0;
      drain();
      chk("pop_total", 32'(n_pop), 32'd18);

      // illegal entries, then reset with two buffered and consumer ready
      out_ready = 1'b0;
      send(itype(6'h3f, 5'd5, 16'h1234), 32'd9, 32'd9, mk(0, 0, 0, 0, 1, 0, 0));
      send(rtype(6'h21, 5'd6, 5'd0), 32'd9, 32'd9, mk(0, 0, 0, 0, 1, 0, 0));
      @(negedge CLK);
      chk("ill_valid", 32'(out_valid), 32'd1);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_oprn", 32'(oprn), 32'd0);
      chk("ill_full", 32'(in_ready), 32'd0);
      @(posedge CLK);
      #1 RST = 1'b1; out_ready = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      chk("rst2_in_ready", 32'(in_ready), 32'd1);
      chk("rst2_illegal", 32'(illegal), 32'd0);
      chk("rst2_no_pop", 32'(n_pop), 32'd18);
      chk("rst2_flushed", 32'(sb.size()), 32'd2);
      sb.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
